// File: rtl/mario_sprite_sequencer.sv
// Purpose : animation controller for Mario's big-sprite ROMs (stand, walk 1-3, jump);
//           picks ROM + mirror once per video frame and maps each pixel to a ROM address.
// Latency : frame logic updates on frame_tick edges; pixel path has 1 clock latency.
// Ports   : Clk/Reset (sync, active-low); frame_tick, walking, facing_left, airborne,
//           pos_x/pos_y (sprite top-left), DrawX/DrawY (scan position) in;
//           rom_addr, rom_sel, pix_valid, anim_state out (all registered). No backpressure.
module mario_sprite_sequencer #(
    parameter int SPR_W     = 21,
    parameter int SPR_H     = 41,
    parameter int FRAME_DIV = 6,
    parameter int ADDR_W    = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              walking,
    input  logic              facing_left,
    input  logic              airborne,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rom_sel,
    output logic              pix_valid,
    output logic [1:0]        anim_state
);

    localparam logic [1:0] ST_STAND = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_JUMP  = 2'd2;

    localparam logic [5:0]        DIV_LAST = 6'(FRAME_DIV - 1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(SPR_W - 1);
    localparam logic [10:0]       W_11     = 11'(SPR_W);
    localparam logic [10:0]       H_11     = 11'(SPR_H);

    // Frame-rate state
    logic [1:0] state;
    logic [1:0] walk_idx;
    logic [5:0] div_cnt;
    logic       mirror;
    logic [9:0] pos_x_l;
    logic [9:0] pos_y_l;

    logic [1:0] state_nxt;
    logic [1:0] walk_nxt;
    logic [5:0] div_nxt;
    logic [2:0] sel_nxt;

    // Tick update: airborne has priority over walking, walking over idle.
    always_comb begin
        state_nxt = state;
        walk_nxt  = walk_idx;
        div_nxt   = div_cnt;
        if (airborne) begin
            state_nxt = ST_JUMP;
        end else if (walking) begin
            if (state == ST_WALK) begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt  = 6'd0;
                    walk_nxt = (walk_idx == 2'd3) ? 2'd1 : walk_idx + 2'd1;
                end else begin
                    div_nxt = div_cnt + 6'd1;
                end
            end else begin
                // Entering WALK restarts the cadence without advancing.
                state_nxt = ST_WALK;
                walk_nxt  = 2'd1;
                div_nxt   = 6'd0;
            end
        end else begin
            state_nxt = ST_STAND;
        end

        case (state_nxt)
            ST_WALK: sel_nxt = {1'b0, walk_nxt};
            ST_JUMP: sel_nxt = 3'd4;
            default: sel_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= ST_STAND;
            walk_idx <= 2'd1;
            div_cnt  <= 6'd0;
            mirror   <= 1'b0;
            pos_x_l  <= 10'd0;
            pos_y_l  <= 10'd0;
            rom_sel  <= 3'd0;
        end else if (frame_tick) begin
            state    <= state_nxt;
            walk_idx <= walk_nxt;
            div_cnt  <= div_nxt;
            mirror   <= facing_left;
            pos_x_l  <= pos_x;
            pos_y_l  <= pos_y;
            rom_sel  <= sel_nxt;
        end
    end

    assign anim_state = state;

    // Pixel path. Offsets are taken with a zero-extended 11-bit subtraction so a
    // negative offset shows up as bit 10 set instead of wrapping into the box.
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              inbox;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_nxt;

    always_comb begin
        dx       = {1'b0, DrawX} - {1'b0, pos_x_l};
        dy       = {1'b0, DrawY} - {1'b0, pos_y_l};
        inbox    = !dx[10] && !dy[10] && (dx < W_11) && (dy < H_11);
        col      = mirror ? (W_LAST - ADDR_W'(dx)) : ADDR_W'(dx);
        addr_nxt = inbox ? (ADDR_W'(dy) * W_A + col) : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rom_addr  <= '0;
            pix_valid <= 1'b0;
        end else begin
            rom_addr  <= addr_nxt;
            pix_valid <= inbox;
        end
    end

endmodule

// File: tb/tb_mario_sprite_sequencer.sv
// Purpose : self-checking bench for mario_sprite_sequencer against a behavioural model.
// Latency : model predicts outputs one clock after the inputs are applied.
// Ports   : none; drives the DUT and prints one summary line.
module tb_mario_sprite_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       walking;
    logic       facing_left;
    logic       airborne;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] rom_addr;
    logic [2:0] rom_sel;
    logic       pix_valid;
    logic [1:0] anim_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: animation state plus number of ticks spent walking
    // since entering WALK; the walk frame follows directly from that count.
    int m_state;
    int m_n;
    int m_mirror;
    int m_px;
    int m_py;

    int e_addr;
    int e_valid;
    int e_sel;
    int e_state;

    mario_sprite_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .walking    (walking),
        .facing_left(facing_left),
        .airborne   (airborne),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_addr   (rom_addr),
        .rom_sel    (rom_sel),
        .pix_valid  (pix_valid),
        .anim_state (anim_state)
    );

    always #5 Clk = ~Clk;

    // Advance one clock, predicting the outputs that edge produces.
    task automatic step();
        int dx;
        int dy;
        if (!Reset) begin
            m_state = 0; m_n = 0; m_mirror = 0; m_px = 0; m_py = 0;
            e_addr = 0; e_valid = 0;
        end else begin
            dx = int'(DrawX) - m_px;
            dy = int'(DrawY) - m_py;
            e_valid = (dx >= 0 && dx < 21 && dy >= 0 && dy < 41) ? 1 : 0;
            e_addr  = e_valid ? dy * 21 + (m_mirror ? 20 - dx : dx) : 0;
            if (frame_tick) begin
                if (airborne) m_state = 2;
                else if (walking) begin
                    if (m_state == 1) m_n++;
                    else begin m_state = 1; m_n = 0; end
                end else m_state = 0;
                m_mirror = facing_left ? 1 : 0;
                m_px = int'(pos_x);
                m_py = int'(pos_y);
            end
        end
        e_state = m_state;
        e_sel   = (m_state == 0) ? 0 : (m_state == 2) ? 4 : 1 + (m_n / 6) % 3;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; frame_tick = 0; walking = 0; facing_left = 0; airborne = 0;
        pos_x = 0; pos_y = 0; DrawX = 10'd500; DrawY = 10'd500;
        step();
        step();
        Reset = 1'b1;
        n_cmp++; if (rom_sel !== 3'd0) begin n_bad++; $display("FAIL reset_rom_sel got %0d want 0", rom_sel); end
        n_cmp++; if (anim_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", anim_state); end
        n_cmp++; if (rom_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0d want 0", pix_valid); end
        step();
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got %0d want 0", pix_valid); end
    endtask

    task automatic test_walk_cadence();
        int want;
        walking = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            do_tick();
            want = (t < 7) ? 1 : (t < 13) ? 2 : (t < 19) ? 3 : 1;
            n_cmp++; if (int'(rom_sel) != want) begin n_bad++; $display("FAIL walk_sel tick%0d got %0d want %0d", t, rom_sel, want); end
            n_cmp++; if (int'(rom_sel) != e_sel) begin n_bad++; $display("FAIL walk_model tick%0d got %0d want %0d", t, rom_sel, e_sel); end
            step();
            n_cmp++; if (int'(rom_sel) != want) begin n_bad++; $display("FAIL walk_hold tick%0d got %0d want %0d", t, rom_sel, want); end
        end
        n_cmp++; if (anim_state !== 2'd1) begin n_bad++; $display("FAIL walk_state got %0d want 1", anim_state); end
    endtask

    task automatic test_jump();
        int guard = 0;
        while (e_sel != 2 && guard < 20) begin do_tick(); guard++; end
        n_cmp++; if (rom_sel !== 3'd2) begin n_bad++; $display("FAIL jump_pre_sel got %0d want 2", rom_sel); end
        airborne = 1'b1;
        do_tick();
        n_cmp++; if (rom_sel !== 3'd4) begin n_bad++; $display("FAIL jump_sel got %0d want 4", rom_sel); end
        n_cmp++; if (anim_state !== 2'd2) begin n_bad++; $display("FAIL jump_state got %0d want 2", anim_state); end
        airborne = 1'b0; walking = 1'b0;
        do_tick();
        n_cmp++; if (rom_sel !== 3'd0) begin n_bad++; $display("FAIL land_sel got %0d want 0", rom_sel); end
        n_cmp++; if (anim_state !== 2'd0) begin n_bad++; $display("FAIL land_state got %0d want 0", anim_state); end
    endtask

    task automatic test_pixel_map();
        pos_x = 10'd100; pos_y = 10'd200; facing_left = 1'b0;
        do_tick();
        DrawX = 10'd100; DrawY = 10'd200; step();
        n_cmp++; if (rom_addr !== 10'd0 || pix_valid !== 1'b1) begin n_bad++; $display("FAIL pix_origin got addr %0d valid %0d want 0 1", rom_addr, pix_valid); end
        DrawX = 10'd120; DrawY = 10'd240; step();
        n_cmp++; if (rom_addr !== 10'd860 || pix_valid !== 1'b1) begin n_bad++; $display("FAIL pix_corner got addr %0d valid %0d want 860 1", rom_addr, pix_valid); end
        DrawX = 10'd121; step();
        n_cmp++; if (rom_addr !== 10'd0 || pix_valid !== 1'b0) begin n_bad++; $display("FAIL pix_outside got addr %0d valid %0d want 0 0", rom_addr, pix_valid); end
    endtask

    task automatic test_mirror();
        facing_left = 1'b1;
        do_tick();
        DrawX = 10'd100; DrawY = 10'd201; step();
        n_cmp++; if (rom_addr !== 10'd41 || pix_valid !== 1'b1) begin n_bad++; $display("FAIL mirror_addr got %0d valid %0d want 41 1", rom_addr, pix_valid); end
        pos_x = 10'd300; step(); step();
        n_cmp++; if (rom_addr !== 10'd41 || pix_valid !== 1'b1) begin n_bad++; $display("FAIL no_tick_pos got %0d valid %0d want 41 1", rom_addr, pix_valid); end
    endtask

    task automatic test_offscreen_and_reset();
        pos_x = 10'd630; pos_y = 10'd200;
        do_tick();
        DrawX = 10'd635; DrawY = 10'd200; step();
        // mirror still set: col = 20-5
        n_cmp++; if (rom_addr !== 10'd15 || pix_valid !== 1'b1) begin n_bad++; $display("FAIL edge_in got %0d valid %0d want 15 1", rom_addr, pix_valid); end
        DrawX = 10'd3; step();
        n_cmp++; if (pix_valid !== 1'b0 || rom_addr !== 10'd0) begin n_bad++; $display("FAIL edge_wrap got %0d valid %0d want 0 0", rom_addr, pix_valid); end
        walking = 1'b1;
        for (int i = 0; i < 9; i++) do_tick();
        DrawX = 10'd640; Reset = 1'b0;
        do_tick();
        Reset = 1'b1;
        n_cmp++; if (rom_sel !== 3'd0 || anim_state !== 2'd0 || rom_addr !== 10'd0 || pix_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_tick got sel %0d st %0d addr %0d valid %0d want 0 0 0 0", rom_sel, anim_state, rom_addr, pix_valid);
        end
        walking = 1'b0;
        do_tick();
        n_cmp++; if (rom_sel !== 3'd0) begin n_bad++; $display("FAIL reset_walkidx got %0d want 0", rom_sel); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(0, 199) != 0);
            frame_tick  = ($urandom_range(0, 5) == 0);
            walking     = ($urandom_range(0, 3) != 0);
            airborne    = ($urandom_range(0, 4) == 0);
            facing_left = $urandom_range(0, 1) != 0;
            pos_x       = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
            pos_y       = 10'($urandom);
            DrawX       = 10'(m_px + int'($urandom_range(0, 26)) - 3);
            DrawY       = 10'(m_py + int'($urandom_range(0, 46)) - 3);
            step();
            n_cmp++; if (int'(rom_addr) != e_addr) begin n_bad++; $display("FAIL rnd_addr i%0d got %0d want %0d", i, rom_addr, e_addr); end
            n_cmp++; if (int'(pix_valid) != e_valid) begin n_bad++; $display("FAIL rnd_valid i%0d got %0d want %0d", i, pix_valid, e_valid); end
            n_cmp++; if (int'(rom_sel) != e_sel) begin n_bad++; $display("FAIL rnd_sel i%0d got %0d want %0d", i, rom_sel, e_sel); end
            n_cmp++; if (int'(anim_state) != e_state) begin n_bad++; $display("FAIL rnd_state i%0d got %0d want %0d", i, anim_state, e_state); end
        end
        Reset = 1'b1; frame_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk_cadence();
        test_jump();
        test_pixel_map();
        test_mirror();
        test_offscreen_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
